// File: rtl/alu_sequencer_if.sv
// Control/status bundle between the ALU sequencer and the split-accumulator datapath.
// The sequencer is the master: it drives the control strobes and samples start/opcode/status.
interface alu_sequencer_if;
  logic       start;
  logic [2:0] opcode;
  logic       alu_lsb;
  logic       cout;
  logic       carry_flag;
  logic       op_add;
  logic       op_sub;
  logic       op_mul;
  logic       op_div;
  logic       op_and;
  logic       acc_in_select;
  logic [1:0] acc_high_select;
  logic [1:0] acc_low_select;
  logic       fill_value;
  logic       acc_high_reset_p;
  logic       rd_en;
  logic       operand_ack;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  start, opcode, alu_lsb, cout, carry_flag,
    output op_add, op_sub, op_mul, op_div, op_and, acc_in_select, acc_high_select,
           acc_low_select, fill_value, acc_high_reset_p, rd_en, operand_ack, busy, done, err
  );

  modport slave (
    output start, opcode, alu_lsb, cout, carry_flag,
    input  op_add, op_sub, op_mul, op_div, op_and, acc_in_select, acc_high_select,
           acc_low_select, fill_value, acc_high_reset_p, rd_en, operand_ack, busy, done, err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Control sequencer for the 4-bit ALU / split accumulator datapath.
// Runs single-step ADD/SUB/AND and multi-cycle shift-add MUL and restoring DIV.
module alu_sequencer #(
  parameter int unsigned ITER = 4
) (
  input logic             clk,
  input logic             reset_p,
  alu_sequencer_if.master ctl
);

  localparam int unsigned CntW = $clog2(ITER + 1);
  localparam logic [CntW-1:0] IterCnt = CntW'(ITER);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpMul = 3'b011;
  localparam logic [2:0] OpDiv = 3'b100;

  localparam logic [1:0] SelHold = 2'b00;
  localparam logic [1:0] SelShr  = 2'b01;
  localparam logic [1:0] SelShl  = 2'b10;
  localparam logic [1:0] SelLoad = 2'b11;

  typedef enum logic [3:0] {
    StIdle, StLoad, StExec, StXfer, StClr, StMadd, StMshr, StDshl, StDsub, StDfix, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            clr_q;
  logic            err_q, err_d;
  logic            legal;

  assign legal = (ctl.opcode <= OpDiv);

  // State, iteration counter, latched opcode and the two registered pulse outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpAdd;
      clr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      // Flop tracks next state so it is high exactly during CLR, free of decode glitches.
      clr_q   <= (state_d == StClr);
      err_q   <= err_d;
    end
  end

  // Next-state, counter and opcode capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctl.start) begin
          if (legal) begin
            state_d = StLoad;
            op_d    = ctl.opcode;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: state_d = ((op_q == OpMul) || (op_q == OpDiv)) ? StXfer : StExec;
      StExec: state_d = StDone;
      StXfer: state_d = StClr;
      StClr: begin
        cnt_d   = '0;
        state_d = (op_q == OpMul) ? StMadd : StDshl;
      end
      StMadd: state_d = StMshr;
      StMshr: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == IterCnt) ? StDone : StMadd;
      end
      StDshl: state_d = StDsub;
      StDsub: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == IterCnt) ? StDfix : StDshl;
      end
      StDfix: state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath control decode from the registered state (MADD/DSUB also look at status).
  always_comb begin
    ctl.op_add          = 1'b0;
    ctl.op_sub          = 1'b0;
    ctl.op_mul          = 1'b0;
    ctl.op_div          = 1'b0;
    ctl.op_and          = 1'b0;
    ctl.acc_in_select   = 1'b0;
    ctl.acc_high_select = SelHold;
    ctl.acc_low_select  = SelHold;
    ctl.fill_value      = 1'b0;
    ctl.rd_en           = 1'b0;
    ctl.operand_ack     = 1'b0;
    ctl.done            = 1'b0;
    ctl.busy            = (state_q != StIdle);
    unique case (state_q)
      StLoad: begin
        ctl.acc_in_select   = 1'b1;
        ctl.acc_high_select = SelLoad;
        ctl.operand_ack     = 1'b1;
      end
      StExec: begin
        ctl.op_add          = (op_q == OpAdd);
        ctl.op_sub          = (op_q == OpSub);
        ctl.op_and          = (op_q == OpAnd);
        ctl.acc_high_select = SelLoad;
      end
      StXfer: ctl.acc_low_select = SelLoad;
      StMadd: begin
        ctl.op_mul          = 1'b1;
        ctl.acc_high_select = ctl.alu_lsb ? SelLoad : SelHold;
      end
      StMshr: begin
        ctl.acc_high_select = SelShr;
        ctl.acc_low_select  = SelShr;
        ctl.fill_value      = ctl.carry_flag;
      end
      StDshl: begin
        ctl.acc_high_select = SelShl;
        ctl.acc_low_select  = SelShl;
        // No quotient bit exists yet on the first shift.
        ctl.fill_value      = (cnt_q == '0) ? 1'b0 : ctl.carry_flag;
      end
      StDsub: begin
        ctl.op_div          = 1'b1;
        ctl.acc_high_select = ctl.cout ? SelLoad : SelHold;
      end
      StDfix: begin
        ctl.acc_low_select = SelShl;
        ctl.fill_value     = ctl.carry_flag;
      end
      StDone: begin
        ctl.rd_en = 1'b1;
        ctl.done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctl.acc_high_reset_p = clr_q;
  assign ctl.err              = err_q;

endmodule
